// File: rtl/value_timer_multi.sv
// Multi-channel prescaled timer: each channel counts D ticks of (P+1) clocks after a
// rising trigger, pulsing once on expiry (one-shot) or every period (auto-reload).
//   state    | meaning
//   idle     | busy=0, waiting for a trigger rising edge
//   counting | busy=1, prescale counter cycling, duration counter falling to 1
module value_timer_multi #(
    parameter int NUM_CH         = 4,
    parameter int TIMER_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_CH-1:0]             tim_trig,
    input  logic [NUM_CH-1:0]             tim_stop,
    input  logic [NUM_CH-1:0]             periodic,
    input  logic [NUM_CH*TIMER_WIDTH-1:0] duration,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic [NUM_CH-1:0]             pulse_out,
    output logic [NUM_CH-1:0]             busy,
    output logic                          pulse_any
);
    localparam logic [TIMER_WIDTH-1:0]    DUR_ONE = TIMER_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = PRESCALE_WIDTH'(1);

    logic [NUM_CH-1:0] pulse_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [TIMER_WIDTH-1:0]    dur_raw, dur_in, dur_q, dcnt_q;
        logic [PRESCALE_WIDTH-1:0] psc_q, pcnt_q;
        logic                      per_q, trig_q, busy_q, pulse_q;
        logic                      trig_evt, wrap, expire;

        assign dur_raw  = duration[i*TIMER_WIDTH +: TIMER_WIDTH];
        assign dur_in   = (dur_raw == '0) ? DUR_ONE : dur_raw;
        assign trig_evt = tim_trig[i] & ~trig_q;
        assign wrap     = busy_q & (pcnt_q == psc_q);
        // Duration counter never reaches zero while busy, so 1 is the terminal count.
        assign expire   = wrap & (dcnt_q == DUR_ONE);

        assign pulse_nxt[i] = expire & ~tim_stop[i];
        assign busy[i]      = busy_q;
        assign pulse_out[i] = pulse_q;

        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                trig_q  <= 1'b0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
                per_q   <= 1'b0;
                dur_q   <= '0;
                dcnt_q  <= '0;
                psc_q   <= '0;
                pcnt_q  <= '0;
            end else begin
                trig_q  <= tim_trig[i];
                pulse_q <= pulse_nxt[i];
                if (tim_stop[i]) begin
                    busy_q <= 1'b0;
                    pcnt_q <= '0;
                    dcnt_q <= '0;
                end else if (trig_evt) begin
                    dur_q  <= dur_in;
                    psc_q  <= prescale;
                    per_q  <= periodic[i];
                    dcnt_q <= dur_in;
                    pcnt_q <= '0;
                    busy_q <= 1'b1;
                end else if (expire) begin
                    pcnt_q <= '0;
                    if (per_q) begin
                        dcnt_q <= dur_q;
                    end else begin
                        busy_q <= 1'b0;
                        dcnt_q <= '0;
                    end
                end else if (wrap) begin
                    pcnt_q <= '0;
                    dcnt_q <= dcnt_q - DUR_ONE;
                end else if (busy_q) begin
                    pcnt_q <= pcnt_q + PSC_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_any <= 1'b0;
        end else begin
            pulse_any <= |pulse_nxt;
        end
    end

endmodule

// File: doc/value_timer_multi.md
VALUE_TIMER_MULTI -- requirements
Module: value_timer_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent timer channels.
REQ-002 The block SHALL have parameter TIMER_WIDTH, default 8: bit width of each channel's duration.
REQ-003 The block SHALL have parameter PRESCALE_WIDTH, default 4: bit width of the shared prescale value.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port tim_trig, input, NUM_CH bits: per-channel start level; the rising edge is detected internally.
REQ-007 The block SHALL have port tim_stop, input, NUM_CH bits: per-channel synchronous abort level.
REQ-008 The block SHALL have port periodic, input, NUM_CH bits: per-channel mode, 0 = one-shot, 1 = auto-reload.
REQ-009 The block SHALL have port duration, input, NUM_CH*TIMER_WIDTH bits: channel i occupies bits [i*TIMER_WIDTH +: TIMER_WIDTH].
REQ-010 The block SHALL have port prescale, input, PRESCALE_WIDTH bits: shared value P; each count tick spans P+1 clocks.
REQ-011 The block SHALL have port pulse_out, output, NUM_CH bits: per-channel registered 1-cycle expiry pulse.
REQ-012 The block SHALL have port busy, output, NUM_CH bits: channel counting.
REQ-013 The block SHALL have port pulse_any, output, 1 bit: registered OR of all pulse_out bits, same cycle as pulse_out.

Function
REQ-014 Each channel SHALL register tim_trig; a trigger event at edge k SHALL occur when tim_trig[i] is sampled 1 at edge k and was 0 at edge k-1.
REQ-015 On a trigger event, the channel SHALL latch duration D, periodic, and the current prescale P; it SHALL zero its prescale counter and set busy from edge k.
REQ-016 D=0 SHALL be treated as D=1.
REQ-017 While busy, the prescale counter SHALL count 0..P and then wrap; the duration counter SHALL decrement once per wrap.
REQ-018 In one-shot mode, pulse_out[i] SHALL be high for exactly the one cycle following edge k+D*(P+1), and busy SHALL clear at that same edge.
REQ-019 In periodic mode, pulse_out[i] SHALL pulse following edges k+n*D*(P+1) for n = 1, 2, ..., reloading the latched D and P each time, with busy staying high.
REQ-020 A trigger event while busy SHALL restart the channel with the new D, P and mode; no pulse SHALL be emitted for the abandoned count.
REQ-021 If a trigger event coincides with the expiry edge, the expiry pulse SHALL still be emitted and the channel SHALL restart with the new values.
REQ-022 tim_stop[i] sampled high SHALL clear busy, suppress any pulse at that edge, and hold the channel idle while high.
REQ-023 If tim_stop[i] and a trigger event coincide, stop SHALL win; the edge-detect register SHALL still update, so no trigger occurs after stop is released while tim_trig stays high.
REQ-024 Changes to duration, periodic or prescale while busy SHALL NOT affect the running count.
REQ-025 Channels SHALL be fully independent.
REQ-026 Internal counters SHALL be wide enough that no intermediate value overflows for D = 2^TIMER_WIDTH-1 and P = 2^PRESCALE_WIDTH-1.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately clear pulse_out, pulse_any, busy, all counters, latched values and trigger-history registers, including mid-count.
REQ-028 After reset release, a tim_trig already high SHALL produce a trigger event at the first clock edge.

Verification
REQ-029 One-shot, P=0, D=5, trigger at edge 10 -> pulse_out[0] high only after edge 15; busy high over edges 10..14.
REQ-030 Periodic, P=2, D=3, trigger at edge 0 -> pulses after edges 9, 18, 27; stop at edge 20 -> no pulse at 27, busy low.
REQ-031 Retrigger at edge 4 with D=6, P=0, after an edge-0 trigger with D=5 -> single pulse after edge 10, none after edge 5.
REQ-032 D=0, P=0 -> pulse after edge k+1; D=255, P=15 -> pulse after edge k+4080.
REQ-033 All 4 channels triggered at the same edge with D=1..4 -> staggered pulses; pulse_any high for four consecutive cycles.
REQ-034 Reset asserted mid-count, then trig held high through release -> outputs zero during reset; fresh count from the first edge after release.
